pending_request_scheduler: RTL
==============================

# pending_request_scheduler

Sequential front end for the 16-input leading-one priority encoder stage. It captures single-cycle request pulses on 16 lines into a sticky pending register. It issues one pending index per handshake, highest index first, as an 8-bit code in the same format the encoder produces: 15..0, or 8'hF0 for "none". A served-count and a sticky overlap flag are provided for the debug/status path.

## Interface
Parameters:
- None. Fixed at 16 request lines, 8-bit code, 8-bit served counter.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset (sampled on clk rising edge).
- req_in  input  16  request pulses; bit i high for any cycle sets pending bit i.
- out_ready  input  1  consumer accepts out_code this cycle when high with out_valid.
- out_valid  output  1  out_code holds a valid issued index.
- out_code  output  8  issued index 8'd0..8'd15; 8'hF0 whenever out_valid=0.
- pending  output  16  current pending register (requests not yet issued).
- served_cnt  output  8  count of completed handshakes, wraps modulo 256.
- overlap  output  1  sticky: a request arrived for a bit already pending.
- idle  output  1  combinational: pending==0 and out_valid==0.

## Operation
- Pending register P, output register {out_valid, out_code}.
- load = !out_valid || out_ready (output slot free or being vacated this cycle).
- On load:
  - If P!=0: out_code <= index of highest set bit of registered P, out_valid <= 1, and that bit is cleared from P.
  - If P==0: out_valid <= 0, out_code <= 8'hF0.
- Selection uses registered P only; req_in of the same cycle is never selected directly.
- P update each cycle: P <= (P & ~sel_onehot) | req_in, where sel_onehot is the bit moved to the output (zero if no load, or if P==0).
- Same-cycle clear and set on one bit: set wins. The bit stays pending and is issued again later.
- While out_valid=1 and out_ready=0: out_code and out_valid are held. A higher-index request arriving meanwhile does not preempt; it only joins P.
- A request for the index currently held in the output register (already removed from P) sets P again. That is a re-issue, not an overlap.
- overlap <= 1 when req_in[i] & P[i] & ~sel_onehot[i] for any i. Cleared only by rst.
- served_cnt increments by 1 on each out_valid && out_ready cycle. 255 -> 0 wraps silently.
- Reset values: P=16'h0000, out_valid=0, out_code=8'hF0, served_cnt=0, overlap=0. Hence idle=1 and pending=0.
- Reset mid-operation discards all pending and in-flight indices, with no handshake counted. rst has priority over req_in and out_ready in the same cycle.

## Timing
- req_in pulse at edge N is visible in pending after edge N. out_valid rises after edge N+1, given the output slot is free: minimum latency 2 cycles.
- With out_ready held high and k bits pending, k codes are issued on k consecutive cycles in descending index order, with no bubbles.
- After the last handshake with P==0: out_valid=0 and out_code=8'hF0 on the next cycle.
- served_cnt and overlap update one cycle after the causing event.
- idle is purely combinational from registered state (no extra cycle).

## Test plan
- Reset with req_in=16'hFFFF and out_ready=1 held during rst -> after rst release: out_valid=0, out_code=8'hF0, pending=0, served_cnt=0, overlap=0, idle=1.
- req_in=16'h8001 for one cycle (edge N), out_ready=1 -> out_code=15 valid at N+2, out_code=0 at N+3, then out_valid=0/out_code=8'hF0 at N+4; served_cnt=2; overlap=0.
- out_ready=0, req_in=16'h0010 then 16'h0400 two cycles later -> out_code stays 4 until out_ready=1. Next code is 10, and pending=16'h0400 while 4 is held.
- Index 7 in output register (out_ready=0), pulse req_in[7] -> overlap stays 0, pending=16'h0080. After ready, 7 is issued twice, served_cnt +2.
- pending=16'h0022, pulse req_in=16'h0002 while out_ready=0 -> overlap=1 and remains 1 until rst.
- 256 requests each accepted in handshake (bursts of 16'hFFFF, out_ready=1) -> served_cnt returns to 0 after the 256th handshake, with codes 15..0 per burst.

Source files
------------

// File: rtl/pending_request_scheduler.sv
// pending_request_scheduler: sticky request capture with one-at-a-time highest-index issue
//   clk, rst     : clock and synchronous active-high reset
//   req_in       : single-cycle request pulses, one bit per line
//   out_ready    : consumer accepts out_code when high with out_valid
//   out_valid    : out_code holds an issued index
//   out_code     : issued index 0..15, 8'hF0 when nothing is issued
//   pending      : requests captured but not yet issued
//   served_cnt   : completed handshakes, modulo 256
//   overlap      : sticky, a request hit a bit that was already pending
//   idle         : nothing pending and nothing issued
module pending_request_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_in,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_code,
    output logic [15:0] pending,
    output logic [7:0]  served_cnt,
    output logic        overlap,
    output logic        idle
);
    logic [3:0]  hi_idx;
    logic [15:0] sel;
    logic        load;
    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < 16; i++)
            if (pending[i]) hi_idx = 4'(i);
    end
    assign load = !out_valid || out_ready;
    assign sel  = (load && |pending) ? 16'(1) << hi_idx : '0;
    assign idle = pending == '0 && !out_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            out_valid  <= 1'b0;
            out_code   <= 8'hF0;
            served_cnt <= '0;
            overlap    <= 1'b0;
        end else begin
            // a request landing on the bit being issued keeps it pending (set wins)
            pending <= (pending & ~sel) | req_in;
            if (load) begin
                out_valid <= |pending;
                out_code  <= |pending ? {4'h0, hi_idx} : 8'hF0;
            end
            if (out_valid && out_ready) served_cnt <= served_cnt + 8'd1;
            if (|(req_in & pending & ~sel)) overlap <= 1'b1;
        end
    end
endmodule
